// File: rtl/adder_operand_sequencer.sv
// Streams operand pairs through a FIFO into an external combinational adder and registers the sum; optional carry flag via ADDER_OVF_FLAG_EN.
// Latency: a pair accepted at edge k into an empty FIFO produces res_valid=1 after edge k+1; one result per cycle sustained.
// Backpressure: in_ready = !full; res_ready=0 holds res_sum/res_ovf and the FIFO head until the result is taken.
module adder_operand_sequencer #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             in_a,
    input  logic [N-1:0]             in_b,
    output logic [N-1:0]             add_a,
    output logic [N-1:0]             add_b,
    input  logic [N-1:0]             add_sum,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [N-1:0]             res_sum,
    output logic                     res_ovf,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    logic [N-1:0] mem_a [DEPTH];
    logic [N-1:0] mem_b [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [AW:0]  wr_ptr_nxt;
    logic [AW:0]  rd_ptr_nxt;
    logic         empty;
    logic         full;
    logic         push;
    logic         fire;
    logic         empty_nxt;
    logic         res_valid_nxt;
    state_t       state;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push       = in_valid && !full;
    assign fire       = !empty && (!res_valid || res_ready);
    assign in_ready   = !full;
    assign fifo_count = wr_ptr - rd_ptr;

    assign add_a = empty ? '0 : mem_a[rd_ptr[AW-1:0]];
    assign add_b = empty ? '0 : mem_b[rd_ptr[AW-1:0]];

    assign wr_ptr_nxt    = wr_ptr + (AW+1)'(push);
    assign rd_ptr_nxt    = rd_ptr + (AW+1)'(fire);
    assign empty_nxt     = (wr_ptr_nxt == rd_ptr_nxt);
    assign res_valid_nxt = fire ? 1'b1 : (res_ready ? 1'b0 : res_valid);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr[AW-1:0]] <= in_a;
            mem_b[wr_ptr[AW-1:0]] <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_sum   <= '0;
        end else if (fire) begin
            res_valid <= 1'b1;
            res_sum   <= add_sum;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

`ifdef ADDER_OVF_FLAG_EN
    // A wrapped unsigned sum is smaller than either operand exactly when a carry left bit N-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_ovf <= 1'b0;
        end else if (fire) begin
            res_ovf <= (add_sum < add_a);
        end
    end
`else
    assign res_ovf = 1'b0;
`endif

    // Debug-only activity tracker; nothing outside depends on it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (push) state <= RUN;
                end
                RUN: begin
                    if (res_valid && !res_ready && !empty) state <= STALL;
                    else if (empty_nxt && !res_valid_nxt) state <= IDLE;
                end
                STALL: begin
                    if (res_ready) state <= RUN;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Randomized and directed bench for adder_operand_sequencer (N=8, DEPTH=4) against a queue-based reference model.
module tb_adder_operand_sequencer;

    localparam int N     = 8;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic [N-1:0] add_a;
    logic [N-1:0] add_b;
    logic [N-1:0] add_sum;
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] res_sum;
    logic         res_ovf;
    logic [2:0]   fifo_count;

    typedef struct packed {
        logic [N-1:0] sum;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic last_acc;

    always #5 clk = ~clk;

    // Behavioural stand-in for the attached combinational adder.
    assign add_sum = add_a + add_b;

    adder_operand_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_sum    (add_sum),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_ovf    (res_ovf),
        .fifo_count (fifo_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N:0] wide;
        exp_t       e;
        wide  = {1'b0, a} + {1'b0, b};
        e.sum = wide[N-1:0];
`ifdef ADDER_OVF_FLAG_EN
        e.ovf = wide[N];
`else
        e.ovf = 1'b0;
`endif
        return e;
    endfunction

    task automatic rand_pair();
        in_a = 8'($urandom_range(255));
        in_b = 8'($urandom_range(255));
    endtask

    // Called just after a negedge with inputs set; returns at the following negedge.
    task automatic cycle();
        logic         acc;
        logic         con;
        logic         hold;
        logic [N-1:0] held_sum;
        logic         held_ovf;
        #1;
        acc      = in_valid && in_ready;
        con      = res_valid && res_ready;
        hold     = res_valid && !res_ready;
        held_sum = res_sum;
        held_ovf = res_ovf;
        if (con) begin
            chk("res_avail", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                chk("res_sum", res_sum, exp_q[0].sum);
                chk("res_ovf", res_ovf, exp_q[0].ovf);
                void'(exp_q.pop_front());
            end
        end
        if (acc) exp_q.push_back(model(in_a, in_b));
        last_acc = acc;
        @(posedge clk);
        #1;
        if (hold) begin
            chk("hold_vld", res_valid, 1);
            chk("hold_sum", res_sum, held_sum);
            chk("hold_ovf", res_ovf, held_ovf);
        end
        @(negedge clk);
    endtask

    initial begin
        int accepted;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        res_ready = 1'b0;
        last_acc  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_vld", res_valid, 0);
        chk("rst_rdy", in_ready, 1);
        chk("rst_cnt", fifo_count, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_sum", res_sum, 0);
        chk("rst_ovf", res_ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single pair: latency and basic sum.
        in_valid  = 1'b1;
        in_a      = 8'h12;
        in_b      = 8'h34;
        res_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("lat_vld0", res_valid, 0);
        chk("lat_cnt1", fifo_count, 1);
        chk("head_a", add_a, 8'h12);
        chk("head_b", add_b, 8'h34);
        cycle();
        chk("lat_vld1", res_valid, 1);
        chk("lat_sum", res_sum, 8'h46);
        chk("lat_cnt0", fifo_count, 0);
        cycle();
        chk("idle_vld", res_valid, 0);

        // Fill under backpressure: one pair lands in the result reg, four in the FIFO.
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("fill_rdy", in_ready, 1);
            in_valid = 1'b1;
            rand_pair();
            cycle();
        end
        chk("full_rdy", in_ready, 0);
        chk("full_cnt", fifo_count, 4);
        chk("full_vld", res_valid, 1);
        rand_pair();
        cycle();
        chk("full_nopush", fifo_count, 4);

        // Release and stream 8 more pairs back-to-back.
        res_ready = 1'b1;
        accepted  = 0;
        for (int i = 0; i < 40 && accepted < 8; i++) begin
            in_valid = 1'b1;
            cycle();
            if (last_acc) begin
                accepted++;
                rand_pair();
            end
        end
        chk("stream_acc", accepted, 8);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            chk("tput_vld", res_valid, 1);
            cycle();
        end
        chk("stream_drain", exp_q.size(), 0);

        // Wrapping sum and carry flag.
        in_valid = 1'b1;
        in_a     = 8'hFF;
        in_b     = 8'h02;
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("wrap_vld", res_valid, 1);
        chk("wrap_sum", res_sum, 8'h01);
`ifdef ADDER_OVF_FLAG_EN
        chk("wrap_ovf", res_ovf, 1);
`else
        chk("wrap_ovf", res_ovf, 0);
`endif
        cycle();

        // Asynchronous reset with queued and pending results.
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            rand_pair();
            cycle();
        end
        in_valid = 1'b0;
        chk("pre_rst_cnt", fifo_count, 3);
        chk("pre_rst_vld", res_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", res_valid, 0);
        chk("arst_cnt", fifo_count, 0);
        chk("arst_rdy", in_ready, 1);
        chk("arst_add_a", add_a, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Random traffic with random backpressure.
        for (int i = 0; i < 200; i++) begin
            in_valid  = ($urandom_range(1) == 1);
            res_ready = ($urandom_range(1) == 1);
            rand_pair();
            cycle();
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
        chk("rand_lost", exp_q.size(), 0);
        chk("end_vld", res_valid, 0);
        chk("end_cnt", fifo_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
